// File: rtl/scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// scoreboard_ctrl
//
// CDC 6600-style scoreboard controller. Accepts at most one instruction per
// cycle and tracks, for every functional unit (FU), its destination and
// source registers (Fi/Fj/Fk), the FUs producing its sources (Qj/Qk) and
// whether those sources are ready to read (Rj/Rk). For every architectural
// register it tracks which FU, if any, will write it (result status).
// Each FU walks IDLE -> ISSUED -> EXEC -> WAIT_WB -> IDLE. The controller
// blocks on structural, WAW, RAW and WAR hazards. The FU datapaths and the
// register file live outside; this block only emits grant pulses and the
// write-back register number.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   in_valid  instruction offered
//   in_ready  instruction can issue this cycle (combinational)
//   in_fu     target functional unit
//   in_dst    destination register
//   in_src1   source register j
//   in_src2   source register k
//   rd_grant  per-FU pulse: read operands and start executing
//   fu_done   per-FU pulse from the datapath: execution complete
//   wb_grant  one-hot registered pulse: FU may write its result
//   wb_reg    destination register of the granted writer (registered)
//   fu_busy   per-FU occupied flag (state != IDLE)
// ---------------------------------------------------------------------------
module scoreboard_ctrl #(
    parameter int n_fu  = 4,
    parameter int n_reg = 8,
    parameter int w_fu  = $clog2(n_fu),
    parameter int w_reg = $clog2(n_reg)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [w_fu-1:0]  in_fu,
    input  logic [w_reg-1:0] in_dst,
    input  logic [w_reg-1:0] in_src1,
    input  logic [w_reg-1:0] in_src2,
    output logic [n_fu-1:0]  rd_grant,
    input  logic [n_fu-1:0]  fu_done,
    output logic [n_fu-1:0]  wb_grant,
    output logic [w_reg-1:0] wb_reg,
    output logic [n_fu-1:0]  fu_busy
);

    typedef enum logic [1:0] {
        FU_IDLE    = 2'd0,
        FU_ISSUED  = 2'd1,
        FU_EXEC    = 2'd2,
        FU_WAIT_WB = 2'd3
    } fuState_t;

    // Per-FU state and scoreboard fields
    fuState_t         r_state     [n_fu];
    fuState_t         w_nextState [n_fu];
    logic [w_reg-1:0] r_fi        [n_fu];
    logic [w_reg-1:0] r_fj        [n_fu];
    logic [w_reg-1:0] r_fk        [n_fu];
    logic [w_fu-1:0]  r_qj        [n_fu];
    logic [w_fu-1:0]  r_qk        [n_fu];
    logic [n_fu-1:0]  r_rj;
    logic [n_fu-1:0]  r_rk;

    // Register result status: valid bit plus producing FU
    logic [n_reg-1:0] r_rsValid;
    logic [w_fu-1:0]  r_rsFu [n_reg];

    // Registered write-back grant
    logic [n_fu-1:0]  r_wbGrant;
    logic [w_reg-1:0] r_wbReg;

    // Combinational helpers
    logic [n_fu-1:0]  w_busy;
    logic [n_fu-1:0]  w_issuedVec;
    logic [n_fu-1:0]  w_rdGrant;
    logic             w_issue;
    logic [n_fu-1:0]  w_issueOh;
    logic             w_srcJBusy;
    logic             w_srcKBusy;
    logic [w_fu-1:0]  w_srcJFu;
    logic [w_fu-1:0]  w_srcKFu;
    logic             w_issueRj;
    logic             w_issueRk;
    logic [w_fu-1:0]  w_issueQj;
    logic [w_fu-1:0]  w_issueQk;
    logic             w_wbFire;
    logic [w_fu-1:0]  w_wbFu;
    logic [n_fu-1:0]  w_effRj;
    logic [n_fu-1:0]  w_effRk;
    logic [n_fu-1:0]  w_cand;
    logic [n_fu-1:0]  w_war;
    logic [n_fu-1:0]  w_elig;
    logic [n_fu-1:0]  w_wbSelOh;
    logic [w_fu-1:0]  w_wbSel;
    logic             w_wbAny;

    // FU state register: the first of the three FSM processes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < n_fu; f++) begin
                r_state[f] <= FU_IDLE;
            end
        end else begin
            for (int f = 0; f < n_fu; f++) begin
                r_state[f] <= w_nextState[f];
            end
        end
    end

    // Next-state logic for every FU. An FU leaves WAIT_WB only at the end of
    // the cycle in which its registered wb_grant is high, which keeps it busy
    // through the grant cycle so a same-cycle issue to it is blocked.
    always_comb begin
        for (int f = 0; f < n_fu; f++) begin
            w_nextState[f] = r_state[f];
            unique case (r_state[f])
                FU_IDLE: begin
                    if (w_issueOh[f]) w_nextState[f] = FU_ISSUED;
                end
                FU_ISSUED: begin
                    if (w_rdGrant[f]) w_nextState[f] = FU_EXEC;
                end
                FU_EXEC: begin
                    if (fu_done[f]) w_nextState[f] = FU_WAIT_WB;
                end
                FU_WAIT_WB: begin
                    if (r_wbGrant[f]) w_nextState[f] = FU_IDLE;
                end
                default: w_nextState[f] = FU_IDLE;
            endcase
        end
    end

    // FSM outputs: busy flags, read-operand grants and the issue handshake.
    // in_ready uses the registered result status, so a destination whose
    // producer is writing back this very cycle still stalls for one cycle.
    always_comb begin
        w_busy      = '0;
        w_issuedVec = '0;
        w_rdGrant   = '0;
        for (int f = 0; f < n_fu; f++) begin
            w_busy[f]      = (r_state[f] != FU_IDLE);
            w_issuedVec[f] = (r_state[f] == FU_ISSUED);
            w_rdGrant[f]   = (r_state[f] == FU_ISSUED) && r_rj[f] && r_rk[f];
        end
        in_ready = rst && !w_busy[in_fu] && !r_rsValid[in_dst];
        w_issue  = in_valid && in_ready;
        w_issueOh = '0;
        for (int f = 0; f < n_fu; f++) begin
            w_issueOh[f] = w_issue && (in_fu == w_fu'(f));
        end
    end

    // Source operand lookup at issue. The result status is read before the
    // issuing instruction updates it, so a source equal to the destination
    // refers to the previous producer. A producer that holds wb_grant this
    // cycle is writing the value now, so the operand counts as ready.
    always_comb begin
        w_srcJBusy = r_rsValid[in_src1];
        w_srcKBusy = r_rsValid[in_src2];
        w_srcJFu   = r_rsFu[in_src1];
        w_srcKFu   = r_rsFu[in_src2];
        w_issueQj  = w_srcJBusy ? w_srcJFu : '0;
        w_issueQk  = w_srcKBusy ? w_srcKFu : '0;
        w_issueRj  = !w_srcJBusy || r_wbGrant[w_srcJFu];
        w_issueRk  = !w_srcKBusy || r_wbGrant[w_srcKFu];
    end

    // Decode the FU currently holding the write-back grant.
    always_comb begin
        w_wbFire = |r_wbGrant;
        w_wbFu   = '0;
        for (int f = 0; f < n_fu; f++) begin
            if (r_wbGrant[f]) w_wbFu = w_fu'(f);
        end
    end

    // Write-back arbitration, evaluated one cycle ahead because the grant is
    // registered. Candidates are FUs already waiting to write, or finishing
    // execution this cycle. A candidate is held off while any issued FU still
    // needs to read the old value of its destination (WAR). An FU that is
    // reading its operands this cycle no longer needs them by the time the
    // registered grant appears, so its pending reads are masked out.
    always_comb begin
        w_effRj   = w_issuedVec & r_rj & ~w_rdGrant;
        w_effRk   = w_issuedVec & r_rk & ~w_rdGrant;
        w_cand    = '0;
        w_war     = '0;
        w_elig    = '0;
        w_wbSelOh = '0;
        w_wbSel   = '0;
        w_wbAny   = 1'b0;
        for (int f = 0; f < n_fu; f++) begin
            w_cand[f] = ((r_state[f] == FU_WAIT_WB) ||
                         ((r_state[f] == FU_EXEC) && fu_done[f])) &&
                        !r_wbGrant[f];
            for (int g = 0; g < n_fu; g++) begin
                if (((r_fj[g] == r_fi[f]) && w_effRj[g]) ||
                    ((r_fk[g] == r_fi[f]) && w_effRk[g])) begin
                    w_war[f] = 1'b1;
                end
            end
            w_elig[f] = w_cand[f] && !w_war[f];
        end
        for (int f = 0; f < n_fu; f++) begin
            if (w_elig[f] && !w_wbAny) begin
                w_wbAny      = 1'b1;
                w_wbSelOh[f] = 1'b1;
                w_wbSel      = w_fu'(f);
            end
        end
    end

    // Write-back grant and register number are registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbGrant <= '0;
            r_wbReg   <= '0;
        end else begin
            r_wbGrant <= w_wbSelOh;
            r_wbReg   <= w_wbAny ? r_fi[w_wbSel] : '0;
        end
    end

    // Register result status. A write-back frees its destination; an issue
    // claims one. They never target the same register in one cycle because
    // issue stalls while the destination still has a producer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsValid <= '0;
            for (int r = 0; r < n_reg; r++) begin
                r_rsFu[r] <= '0;
            end
        end else begin
            if (w_wbFire) begin
                r_rsValid[r_fi[w_wbFu]] <= 1'b0;
            end
            if (w_issue) begin
                r_rsValid[in_dst] <= 1'b1;
                r_rsFu[in_dst]    <= in_fu;
            end
        end
    end

    // Per-FU scoreboard fields. Issue loads all fields. A read-operand grant
    // clears Rj/Rk so the operands no longer block a WAR writer. A write-back
    // wakes every issued FU whose pending source was produced by the writer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rj <= '0;
            r_rk <= '0;
            for (int f = 0; f < n_fu; f++) begin
                r_fi[f] <= '0;
                r_fj[f] <= '0;
                r_fk[f] <= '0;
                r_qj[f] <= '0;
                r_qk[f] <= '0;
            end
        end else begin
            for (int f = 0; f < n_fu; f++) begin
                if (w_issueOh[f]) begin
                    r_fi[f] <= in_dst;
                    r_fj[f] <= in_src1;
                    r_fk[f] <= in_src2;
                    r_qj[f] <= w_issueQj;
                    r_qk[f] <= w_issueQk;
                    r_rj[f] <= w_issueRj;
                    r_rk[f] <= w_issueRk;
                end else if (w_rdGrant[f]) begin
                    r_rj[f] <= 1'b0;
                    r_rk[f] <= 1'b0;
                end else if (w_issuedVec[f] && w_wbFire) begin
                    if (!r_rj[f] && (r_qj[f] == w_wbFu)) r_rj[f] <= 1'b1;
                    if (!r_rk[f] && (r_qk[f] == w_wbFu)) r_rk[f] <= 1'b1;
                end
            end
        end
    end

    assign rd_grant = w_rdGrant;
    assign fu_busy  = w_busy;
    assign wb_grant = r_wbGrant;
    assign wb_reg   = r_wbReg;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scoreboard_ctrl
//
// Directed bench for scoreboard_ctrl. Inputs change just after the falling
// clock edge and outputs are sampled 1 time unit later, well away from the
// rising (active) edge. Every expected value is hand-computed from the
// scoreboard behaviour; cycle offsets in the step comments are relative to
// the first cycle of each scenario (the cycle in which the issue is offered).
// ---------------------------------------------------------------------------
module tb_scoreboard_ctrl;

    localparam int N_FU  = 4;
    localparam int N_REG = 8;
    localparam int W_FU  = 2;
    localparam int W_REG = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W_FU-1:0]  in_fu;
    logic [W_REG-1:0] in_dst;
    logic [W_REG-1:0] in_src1;
    logic [W_REG-1:0] in_src2;
    logic [N_FU-1:0]  rd_grant;
    logic [N_FU-1:0]  fu_done;
    logic [N_FU-1:0]  wb_grant;
    logic [W_REG-1:0] wb_reg;
    logic [N_FU-1:0]  fu_busy;

    int checks = 0;
    int errors = 0;

    scoreboard_ctrl #(
        .n_fu  (N_FU),
        .n_reg (N_REG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_fu    (in_fu),
        .in_dst   (in_dst),
        .in_src1  (in_src1),
        .in_src2  (in_src2),
        .rd_grant (rd_grant),
        .fu_done  (fu_done),
        .wb_grant (wb_grant),
        .wb_reg   (wb_reg),
        .fu_busy  (fu_busy)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge, drive one cycle of inputs, settle
    task automatic applyStimulus(input logic v, input logic [W_FU-1:0] fu,
                                 input logic [W_REG-1:0] dst,
                                 input logic [W_REG-1:0] s1,
                                 input logic [W_REG-1:0] s2,
                                 input logic [N_FU-1:0] done);
        @(negedge clk);
        in_valid = v;
        in_fu    = fu;
        in_dst   = dst;
        in_src1  = s1;
        in_src2  = s2;
        fu_done  = done;
        #1;
    endtask

    // One comparison: count it, and on a miss count and report it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_fu    = '0;
        in_dst   = '0;
        in_src1  = '0;
        in_src2  = '0;
        fu_done  = '0;

        // Reset state
        #2;
        checkOutput("rst_ready", 32'(in_ready), 0);
        checkOutput("rst_busy",  32'(fu_busy),  0);
        checkOutput("rst_rd",    32'(rd_grant), 0);
        checkOutput("rst_wb",    32'(wb_grant), 0);
        checkOutput("rst_wbreg", 32'(wb_reg),   0);
        @(negedge clk);
        rst = 1'b1;

        // Independent op: FU0 r1 = r2 op r3
        $display("[TB] independent op");
        applyStimulus(1, 0, 1, 2, 3, 4'b0000);          // +0
        checkOutput("ind_ready", 32'(in_ready), 1);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +1
        checkOutput("ind_rd",    32'(rd_grant), 4'b0001);
        checkOutput("ind_busy1", 32'(fu_busy),  4'b0001);
        applyStimulus(0, 0, 0, 0, 0, 4'b0001);          // +2
        checkOutput("ind_rd_off", 32'(rd_grant), 0);
        checkOutput("ind_wb_early", 32'(wb_grant), 0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +3
        checkOutput("ind_wb",    32'(wb_grant), 4'b0001);
        checkOutput("ind_wbreg", 32'(wb_reg),   1);
        checkOutput("ind_busy3", 32'(fu_busy),  4'b0001);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +4
        checkOutput("ind_busy4", 32'(fu_busy),  0);
        checkOutput("ind_wb_off", 32'(wb_grant), 0);

        // RAW: FU0 writes r1, FU1 r7 = r1 op r2 must wait for the write
        $display("[TB] RAW");
        applyStimulus(1, 0, 1, 2, 3, 4'b0000);          // +0
        applyStimulus(1, 1, 7, 1, 2, 4'b0000);          // +1
        checkOutput("raw_ready1", 32'(in_ready), 1);
        checkOutput("raw_rd0",    32'(rd_grant), 4'b0001);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +2
        checkOutput("raw_rd_hold2", 32'(rd_grant), 0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +3
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +4
        checkOutput("raw_rd_hold4", 32'(rd_grant), 0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0001);          // +5
        checkOutput("raw_rd_hold5", 32'(rd_grant), 0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +6
        checkOutput("raw_wb0",     32'(wb_grant), 4'b0001);
        checkOutput("raw_wbreg0",  32'(wb_reg),   1);
        checkOutput("raw_rd_hold6", 32'(rd_grant), 0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +7
        checkOutput("raw_rd1",   32'(rd_grant), 4'b0010);
        checkOutput("raw_busy7", 32'(fu_busy),  4'b0010);
        applyStimulus(0, 0, 0, 0, 0, 4'b0010);          // +8
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +9
        checkOutput("raw_wb1",    32'(wb_grant), 4'b0010);
        checkOutput("raw_wbreg1", 32'(wb_reg),   7);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +10
        checkOutput("raw_busy10", 32'(fu_busy), 0);

        // WAW: FU0 and FU1 both target r4
        $display("[TB] WAW");
        applyStimulus(1, 0, 4, 0, 0, 4'b0000);          // +0
        checkOutput("waw_ready0", 32'(in_ready), 1);
        applyStimulus(1, 1, 4, 0, 0, 4'b0000);          // +1
        checkOutput("waw_stall1", 32'(in_ready), 0);
        applyStimulus(1, 1, 4, 0, 0, 4'b0001);          // +2
        checkOutput("waw_stall2", 32'(in_ready), 0);
        applyStimulus(1, 1, 4, 0, 0, 4'b0000);          // +3
        checkOutput("waw_wb0",    32'(wb_grant), 4'b0001);
        checkOutput("waw_stall3", 32'(in_ready), 0);
        applyStimulus(1, 1, 4, 0, 0, 4'b0000);          // +4
        checkOutput("waw_ready4", 32'(in_ready), 1);
        checkOutput("waw_busy4",  32'(fu_busy),  0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +5
        checkOutput("waw_busy5", 32'(fu_busy),  4'b0010);
        checkOutput("waw_rd1",   32'(rd_grant), 4'b0010);
        applyStimulus(0, 0, 0, 0, 0, 4'b0010);          // +6
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +7
        checkOutput("waw_wb1",    32'(wb_grant), 4'b0010);
        checkOutput("waw_wbreg1", 32'(wb_reg),   4);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +8
        checkOutput("waw_busy8", 32'(fu_busy), 0);

        // WAR: FU1 r3 = r5 op r6 waits on FU0 (r6); FU2 writes r5 and
        // finishes first, but must not write until FU1 has read r5
        $display("[TB] WAR");
        applyStimulus(1, 0, 6, 0, 0, 4'b0000);          // +0
        applyStimulus(1, 1, 3, 5, 6, 4'b0000);          // +1
        checkOutput("war_ready1", 32'(in_ready), 1);
        checkOutput("war_rd1",    32'(rd_grant), 4'b0001);
        applyStimulus(1, 2, 5, 0, 0, 4'b0000);          // +2
        checkOutput("war_ready2", 32'(in_ready), 1);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +3
        checkOutput("war_rd3", 32'(rd_grant), 4'b0100);
        applyStimulus(0, 0, 0, 0, 0, 4'b0100);          // +4
        applyStimulus(0, 0, 0, 0, 0, 4'b0001);          // +5
        checkOutput("war_hold5", 32'(wb_grant), 0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +6
        checkOutput("war_wb0",    32'(wb_grant), 4'b0001);
        checkOutput("war_wbreg0", 32'(wb_reg),   6);
        checkOutput("war_rd6",    32'(rd_grant), 0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +7
        checkOutput("war_rd7",   32'(rd_grant), 4'b0010);
        checkOutput("war_hold7", 32'(wb_grant), 0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0010);          // +8
        checkOutput("war_wb2",    32'(wb_grant), 4'b0100);
        checkOutput("war_wbreg2", 32'(wb_reg),   5);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +9
        checkOutput("war_wb1",    32'(wb_grant), 4'b0010);
        checkOutput("war_wbreg1", 32'(wb_reg),   3);
        checkOutput("war_busy9",  32'(fu_busy),  4'b0010);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +10
        checkOutput("war_busy10", 32'(fu_busy), 0);

        // Structural hazard and write-back arbitration
        $display("[TB] structural and arbitration");
        applyStimulus(1, 0, 1, 0, 0, 4'b0000);          // +0
        applyStimulus(1, 2, 2, 0, 0, 4'b0000);          // +1
        checkOutput("arb_rd0", 32'(rd_grant), 4'b0001);
        applyStimulus(1, 0, 3, 0, 0, 4'b0000);          // +2
        checkOutput("arb_rd2",     32'(rd_grant), 4'b0100);
        checkOutput("arb_struct2", 32'(in_ready), 0);
        applyStimulus(1, 0, 3, 0, 0, 4'b0101);          // +3
        checkOutput("arb_struct3", 32'(in_ready), 0);
        applyStimulus(1, 0, 3, 0, 0, 4'b0000);          // +4
        checkOutput("arb_wb0",     32'(wb_grant), 4'b0001);
        checkOutput("arb_wbreg0",  32'(wb_reg),   1);
        checkOutput("arb_struct4", 32'(in_ready), 0);
        applyStimulus(0, 0, 3, 0, 0, 4'b0000);          // +5
        checkOutput("arb_wb2",    32'(wb_grant), 4'b0100);
        checkOutput("arb_wbreg2", 32'(wb_reg),   2);
        checkOutput("arb_ready5", 32'(in_ready), 1);
        checkOutput("arb_busy5",  32'(fu_busy),  4'b0100);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +6
        checkOutput("arb_busy6", 32'(fu_busy),  0);
        checkOutput("arb_wb6",   32'(wb_grant), 0);

        // Reset in the middle of operation with three FUs busy
        $display("[TB] reset mid-operation");
        applyStimulus(1, 0, 1, 0, 0, 4'b0000);          // +0
        applyStimulus(1, 1, 2, 0, 0, 4'b0000);          // +1
        applyStimulus(1, 3, 3, 0, 0, 4'b0000);          // +2
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +3
        checkOutput("mid_busy", 32'(fu_busy),  4'b1011);
        checkOutput("mid_rd",   32'(rd_grant), 4'b1000);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy",  32'(fu_busy),  0);
        checkOutput("mid_rst_rd",    32'(rd_grant), 0);
        checkOutput("mid_rst_wb",    32'(wb_grant), 0);
        checkOutput("mid_rst_ready", 32'(in_ready), 0);
        applyStimulus(1, 1, 2, 0, 0, 4'b1111);          // +4, held in reset
        checkOutput("mid_rst_ready4", 32'(in_ready), 0);
        checkOutput("mid_rst_busy4",  32'(fu_busy),  0);
        checkOutput("mid_rst_wbreg4", 32'(wb_reg),   0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);          // +5
        rst = 1'b1;
        applyStimulus(1, 3, 3, 1, 2, 4'b0000);          // fresh issue
        checkOutput("post_ready", 32'(in_ready), 1);
        checkOutput("post_busy0", 32'(fu_busy),  0);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);
        checkOutput("post_rd",    32'(rd_grant), 4'b1000);
        applyStimulus(0, 0, 0, 0, 0, 4'b1000);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);
        checkOutput("post_wb",    32'(wb_grant), 4'b1000);
        checkOutput("post_wbreg", 32'(wb_reg),   3);
        applyStimulus(0, 0, 0, 0, 0, 4'b0000);
        checkOutput("post_busy", 32'(fu_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
- CDC 6600-style scoreboard controller for the scoreboard lab top.
- Accepts one instruction per cycle (target functional unit plus dst/src register numbers) and tracks per-FU and per-register status.
- Sequences each FU through issue, read-operands, execute and write-result, blocking on structural, WAW, RAW and WAR hazards.
- The FU datapaths and register file sit outside; this block only emits grant pulses and the writeback register number.

Parameters:
- n_fu, 4, number of functional units.
- n_reg, 8, number of architectural registers.
- w_fu, $clog2(n_fu), FU index width.
- w_reg, $clog2(n_reg), register index width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  instruction can issue this cycle.
- in_fu  input  w_fu  target FU.
- in_dst  input  w_reg  destination register.
- in_src1  input  w_reg  source register j.
- in_src2  input  w_reg  source register k.
- rd_grant  output  n_fu  per-FU one-cycle pulse: read operands and start execute.
- fu_done  input  n_fu  per-FU one-cycle pulse: execution complete.
- wb_grant  output  n_fu  one-hot one-cycle pulse: FU may write its result.
- wb_reg  output  w_reg  destination register of the granted writer.
- fu_busy  output  n_fu  FU occupied (state != IDLE).

Behaviour:
- Reset (rst low, asynchronous):
  - all FUs go to IDLE; every register result-status is "none".
  - all Fi/Fj/Fk/Qj/Qk/Rj/Rk fields are 0.
  - rd_grant, wb_grant, fu_busy and wb_reg are 0; in_ready is 0 while in reset.
  - Reset mid-operation discards all in-flight instructions.
- Per-FU state: IDLE -> ISSUED -> EXEC -> WAIT_WB -> IDLE.
- Issue:
  - in_ready = !busy[in_fu] && result_status[in_dst] == none (combinational).
  - Issue is a structural/WAW stall. WAW is checked against the registered status, so a dst whose producer is writing in this same cycle still stalls one cycle.
  - On in_valid && in_ready at the edge, FU in_fu goes to ISSUED.
  - It records Fi = in_dst, Fj = in_src1, Fk = in_src2 and sets result_status[in_dst] = in_fu.
  - Qj = result_status[in_src1]; Rj = 1 if no producer, or if that producer is receiving wb_grant this cycle (bypass); else Rj = 0. Qk/Rk are set the same way.
  - If src1 == in_dst, the old producer is used, never self.
- Read operands:
  - Any FU in ISSUED with Rj && Rk pulses rd_grant for exactly one cycle.
  - In that cycle it clears Rj and Rk (marking the operands consumed, for the WAR check) and moves to EXEC.
  - Multiple FUs may be granted in the same cycle.
- Execute: fu_done[f] in EXEC moves FU f to WAIT_WB. fu_done in any other state is ignored.
- Write result:
  - FU f in WAIT_WB is eligible if no FU g in ISSUED has (Fj[g] == Fi[f] && Rj[g]) or (Fk[g] == Fi[f] && Rk[g]).
  - At most one wb_grant per cycle, to the lowest eligible index.
  - wb_grant and wb_reg are registered outputs.
  - On the grant edge, FU f goes to IDLE and result_status[Fi[f]] becomes none.
  - Every FU g with Qj[g] == f gets Rj = 1 (likewise Qk/Rk).
- Minimum latency: issue edge T0, rd_grant at T0+1, fu_done earliest T0+2, wb_grant at T0+3. fu_busy deasserts the cycle after wb_grant.
- RAW consumer: rd_grant comes no earlier than the cycle after the producer's wb_grant.
- Simultaneous events: an issue to an FU in the same cycle as that FU's wb_grant is blocked (the FU is still busy). A write and a read-operands grant in the same cycle are both allowed.

Test Plan:
- Independent ops: issue FU0 r1 = r2 op r3, hold fu_done[0] at +2 -> in_ready = 1, rd_grant[0] at +1, wb_grant[0] = 1 with wb_reg = 1 at +3, fu_busy[0] = 0 at +4.
- RAW: FU0 writes r1; next cycle FU1 reads r1; fu_done[0] at +5 -> rd_grant[1] held 0 until the cycle after wb_grant[0].
- WAW: FU0 dst r4 in flight, offer FU1 dst r4 -> in_ready = 0 until the cycle after wb_grant[0], then FU1 issues.
- WAR: FU1 reads r5 while stalled on r6 (RAW); FU2 writes r5 and finishes first -> wb_grant[2] withheld until rd_grant[1] fires.
- Structural plus arbitration: FU0 and FU2 finish in the same cycle -> wb_grant[0] first, wb_grant[2] next cycle; a second offer to busy FU0 sees in_ready = 0.
- Reset mid-op: drop rst with 3 FUs busy -> fu_busy = 0 immediately, no grants; after release, a fresh issue proceeds normally.
